// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and datapath widths used by the
// ALU arbiter and anything that talks to the shared 64-bit ALU.
package alu_pkg;
   localparam int ALU_DATA_W = 64;
   localparam int ALU_OP_W   = 3;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b010;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b011;
   localparam logic [ALU_OP_W-1:0] ALU_NZ   = 3'b100;
   localparam logic [ALU_OP_W-1:0] ALU_SHL  = 3'b101;
   localparam logic [ALU_OP_W-1:0] ALU_SHR  = 3'b110;
   localparam logic [ALU_OP_W-1:0] ALU_RSVD = 3'b111;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last. No grant while the response slot is busy.
module rr_arb2 (
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_slot_free,
   input  logic i_last_id,
   output logic o_grant_valid,
   output logic o_grant_id
);
   logic w_both;

   assign w_both        = i_valid0 & i_valid1;
   assign o_grant_valid = i_slot_free & (i_valid0 | i_valid1);
   assign o_grant_id    = w_both ? ~i_last_id : i_valid1;
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (id 0) and the
// address/branch unit (id 1); the result lands in a one-entry response buffer.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int OP_W   = ALU_OP_W,
   parameter int PERF_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,
   output logic              req1_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_err,
   input  logic              rsp_ready,
   output logic [PERF_W-1:0] grant_count0,
   output logic [PERF_W-1:0] grant_count1
);
   logic              r_rsp_valid;
   logic              r_rsp_id;
   logic [DATA_W-1:0] r_rsp_result;
   logic              r_rsp_zero;
   logic              r_rsp_err;
   logic              r_last_id;
   logic [PERF_W-1:0] r_cnt0;
   logic [PERF_W-1:0] r_cnt1;

   logic w_slot_free;
   logic w_grant_valid;
   logic w_grant_id;
   logic w_fire;
   logic w_rsvd;

   assign w_slot_free = ~r_rsp_valid | rsp_ready;

   rr_arb2 u_arb (
      .i_valid0      (req0_valid),
      .i_valid1      (req1_valid),
      .i_slot_free   (w_slot_free),
      .i_last_id     (r_last_id),
      .o_grant_valid (w_grant_valid),
      .o_grant_id    (w_grant_id)
   );

   // A grant is only issued for a valid requester, so grant implies fire.
   assign w_fire     = w_grant_valid & rst_n;
   assign req0_ready = w_fire & ~w_grant_id;
   assign req1_ready = w_fire &  w_grant_id;

   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = '0;
      if (w_grant_valid) begin
         alu_a  = w_grant_id ? req1_a  : req0_a;
         alu_b  = w_grant_id ? req1_b  : req0_b;
         alu_op = w_grant_id ? req1_op : req0_op;
      end
   end

   assign w_rsvd = (alu_op == OP_W'(ALU_RSVD));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_zero   <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_last_id    <= 1'b1;
         r_cnt0       <= '0;
         r_cnt1       <= '0;
      end else if (w_fire) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_id     <= w_grant_id;
         r_rsp_result <= w_rsvd ? '0 : alu_result;
         r_rsp_zero   <= w_rsvd ? 1'b1 : alu_zero;
         r_rsp_err    <= w_rsvd;
         r_last_id    <= w_grant_id;
         if (!w_grant_id && r_cnt0 != '1) r_cnt0 <= r_cnt0 + 1'b1;
         if ( w_grant_id && r_cnt1 != '1) r_cnt1 <= r_cnt1 + 1'b1;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid    = r_rsp_valid;
   assign rsp_id       = r_rsp_id;
   assign rsp_result   = r_rsp_result;
   assign rsp_zero     = r_rsp_zero;
   assign rsp_err      = r_rsp_err;
   assign grant_count0 = r_cnt0;
   assign grant_count1 = r_cnt1;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_alu_arbiter;
   import alu_pkg::*;
   localparam int DW = 64;
   localparam int OW = 3;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [OW-1:0] req0_op, req1_op;
   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic [OW-1:0] alu_op;
   logic          alu_zero;
   logic          rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_ready;
   logic [DW-1:0] rsp_result;
   logic [PW-1:0] grant_count0, grant_count1;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic          m_valid, m_id, m_zero, m_err, m_last;
   logic [DW-1:0] m_res;
   int            m_cnt [2];

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(DW), .OP_W(OW), .PERF_W(PW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .rsp_err(rsp_err), .rsp_ready(rsp_ready),
      .grant_count0(grant_count0), .grant_count1(grant_count1)
   );

   // Behavioural ALU; the reserved code yields a nonzero junk value so that
   // the arbiter's override of result/zero is observable.
   function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_NZ:  return {63'b0, (a != 0)};
         ALU_SHL: return a << b[5:0];
         ALU_SHR: return a >> b[5:0];
         default: return 64'hDEAD_BEEF;
      endcase
   endfunction

   always_comb begin
      alu_result = alu_f(alu_a, alu_b, alu_op);
      alu_zero   = (alu_result == '0);
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_err = 0; m_last = 1;
      m_cnt[0] = 0; m_cnt[1] = 0;
   endtask

   // Inputs are set by the caller just after a falling edge; this checks the
   // cycle, advances through the rising edge and updates the model.
   task automatic tick();
      int            g;
      logic [DW-1:0] a, b;
      logic [OW-1:0] op;
      #1;
      g = -1;
      if (rst_n && (!m_valid || rsp_ready)) begin
         if (req0_valid && req1_valid) g = m_last ? 0 : 1;
         else if (req0_valid)          g = 0;
         else if (req1_valid)          g = 1;
      end
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      chk("rsp_valid",  rsp_valid,  m_valid);
      chk("rsp_id",     rsp_id,     m_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero",   rsp_zero,   m_zero);
      chk("rsp_err",    rsp_err,    m_err);
      chk("cnt0",       grant_count0, m_cnt[0]);
      chk("cnt1",       grant_count1, m_cnt[1]);
      a  = (g == 1) ? req1_a  : req0_a;
      b  = (g == 1) ? req1_b  : req0_b;
      op = (g == 1) ? req1_op : req0_op;
      if (g >= 0) begin
         chk("alu_a",  alu_a,  a);
         chk("alu_b",  alu_b,  b);
         chk("alu_op", alu_op, op);
      end
      @(posedge clk);
      if (!rst_n) model_reset();
      else if (g >= 0) begin
         m_valid = 1;
         m_id    = g[0];
         m_err   = (op == ALU_RSVD);
         m_res   = m_err ? '0 : alu_f(a, b, op);
         m_zero  = m_err ? 1'b1 : (m_res == '0);
         m_last  = g[0];
         if (m_cnt[g] < (1 << PW) - 1) m_cnt[g]++;
      end else if (rsp_ready) m_valid = 0;
      @(negedge clk);
   endtask

   task automatic idle();
      req0_valid = 0; req1_valid = 0;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0; rsp_ready = 1;
      tick();
      rst_n = 1;
   endtask

   initial begin
      idle();
      rst_n = 0; rsp_ready = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      tick();                       // reset state, readys low in reset
      rst_n = 1;

      // single ADD
      req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = ALU_ADD;
      tick();
      idle();
      chk("t1_result", rsp_result, 12);
      chk("t1_id", rsp_id, 0);
      chk("t1_cnt0", grant_count0, 1);
      tick();

      // contention alternates 0,1,0,1
      do_reset();
      req0_valid = 1; req0_a = 10;   req0_b = 10;   req0_op = ALU_SUB;
      req1_valid = 1; req1_a = 'hF0; req1_b = 'h0F; req1_op = ALU_OR;
      repeat (4) tick();
      chk("t2_cnt0", grant_count0, 2);
      chk("t2_cnt1", grant_count1, 2);
      chk("t2_last", rsp_result, 'hFF);

      // backpressure then release
      do_reset();
      idle();
      req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = ALU_ADD;
      tick();
      req1_valid = 1; req1_a = 9; req1_b = 3; req1_op = ALU_SUB;
      rsp_ready = 0;
      repeat (3) tick();
      chk("t3_hold", rsp_result, 2);
      rsp_ready = 1;
      tick();
      chk("t3_id", rsp_id, 1);
      chk("t3_result", rsp_result, 6);

      // reserved opcode
      do_reset();
      req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = ALU_RSVD;
      tick();
      idle();
      chk("t4_err", rsp_err, 1);
      chk("t4_result", rsp_result, 0);
      chk("t4_zero", rsp_zero, 1);
      chk("t4_id", rsp_id, 1);

      // reset while a response is stalled
      req0_valid = 1; req0_a = 2; req0_b = 2; req0_op = ALU_AND;
      rsp_ready = 0;
      tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      chk("t5_valid", rsp_valid, 0);
      chk("t5_cnt1", grant_count1, 0);
      rsp_ready = 1;
      req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = ALU_ADD;
      tick();
      chk("t5_first", rsp_id, 0);

      // counter saturation
      do_reset();
      req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = ALU_ADD;
      repeat (17) tick();
      chk("t6_cnt0", grant_count0, 15);
      chk("t6_cnt1", grant_count1, 0);

      // random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         req0_op = OW'($urandom_range(0, 7));
         req1_op = OW'($urandom_range(0, 7));
         req0_a = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 3));
         req0_b = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 3));
         req1_a = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 3));
         req1_b = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 3));
         rsp_ready = ($urandom_range(0, 2) != 0);
         rst_n = ($urandom_range(0, 60) != 0);
         tick();
      end
      rst_n = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
